// File: rtl/gpio_ctrl_pkg.sv
// gpio_ctrl shared definitions.
// Register word indices, also used by bus decode and firmware headers.
package gpio_ctrl_pkg;

  localparam int ADDR_W = 4;

  typedef enum logic [ADDR_W-1:0] {
    ADDR_DIR     = 4'd0,
    ADDR_OUT     = 4'd1,
    ADDR_OUT_SET = 4'd2,
    ADDR_OUT_CLR = 4'd3,
    ADDR_OUT_TGL = 4'd4,
    ADDR_IN      = 4'd5,
    ADDR_RISE_EN = 4'd6,
    ADDR_FALL_EN = 4'd7,
    ADDR_STAT    = 4'd8
  } gpio_addr_e;

endpackage

// File: rtl/gpio_ctrl_if.sv
// Data-memory bus slice seen by gpio_ctrl.
// One word per register, strobed reads and writes.
interface gpio_ctrl_if
  import gpio_ctrl_pkg::*;
#(
  parameter int DW = 32
);

  logic [ADDR_W-1:0] i_addr;
  logic              i_we;
  logic              i_re;
  logic [DW-1:0]     i_wdata;
  logic [DW-1:0]     o_rdata;
  logic              o_rvalid;

  modport master (
    output i_addr, i_we, i_re, i_wdata,
    input  o_rdata, o_rvalid
  );

  modport slave (
    input  i_addr, i_we, i_re, i_wdata,
    output o_rdata, o_rvalid
  );

endinterface

// File: rtl/gpio_edge_detect.sv
// Pin resynchroniser and per-pin edge detector.
// Edges are masked until two clocks after reset release.
module gpio_edge_detect #(
  parameter int N = 15
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [N:0] pin_i,
  output logic [N:0] sync_o,
  output logic [N:0] rise_o,
  output logic [N:0] fall_o
);

  logic [N:0] s_q;
  logic [N:0] p_q;
  logic       arm_q;
  logic       valid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s_q     <= '0;
      p_q     <= '0;
      arm_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      s_q     <= pin_i;
      p_q     <= s_q;
      arm_q   <= 1'b1;
      valid_q <= arm_q;
    end
  end

  // p_q still holds the reset value until valid_q is up
  assign sync_o = s_q;
  assign rise_o = valid_q ? (s_q & ~p_q) : '0;
  assign fall_o = valid_q ? (~s_q & p_q) : '0;

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO controller: direction/output registers,
// input resync, edge status and a level interrupt.
module gpio_ctrl
  import gpio_ctrl_pkg::*;
#(
  parameter int N  = 15,
  parameter int DW = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  gpio_ctrl_if.slave  bus,
  output logic [N:0]  o_gpio_dir,
  output logic [N:0]  o_gpio_out,
  input  logic [N:0]  i_gpio_in,
  output logic        o_irq
);

  logic [N:0]    dir_q, dir_d;
  logic [N:0]    out_q, out_d;
  logic [N:0]    ren_q, ren_d;
  logic [N:0]    fen_q, fen_d;
  logic [N:0]    stat_q, stat_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rvalid_q;
  logic          irq_q;

  logic [N:0] sync;
  logic [N:0] rise;
  logic [N:0] fall;
  logic [N:0] wd;
  logic [N:0] clr;
  logic [N:0] rd_val;
  logic       unused_wdata;

  gpio_edge_detect #(.N(N)) u_edge (
    .clk_i  (i_clk),
    .rst_i  (i_rst),
    .pin_i  (i_gpio_in),
    .sync_o (sync),
    .rise_o (rise),
    .fall_o (fall)
  );

  assign wd           = bus.i_wdata[N:0];
  assign unused_wdata = ^bus.i_wdata[DW-1:N+1];

  always_comb begin
    dir_d = dir_q;
    out_d = out_q;
    ren_d = ren_q;
    fen_d = fen_q;
    clr   = '0;
    if (bus.i_we) begin
      case (bus.i_addr)
        ADDR_DIR:     dir_d = wd;
        ADDR_OUT:     out_d = wd;
        ADDR_OUT_SET: out_d = out_q | wd;
        ADDR_OUT_CLR: out_d = out_q & ~wd;
        ADDR_OUT_TGL: out_d = out_q ^ wd;
        ADDR_RISE_EN: ren_d = wd;
        ADDR_FALL_EN: fen_d = wd;
        ADDR_STAT:    clr   = wd;
        default:      ;
      endcase
    end
    // new edges override a same-cycle clear
    stat_d = (stat_q & ~clr)
           | (rise & ren_q)
           | (fall & fen_q);
  end

  always_comb begin
    rd_val = '0;
    case (bus.i_addr)
      ADDR_DIR:     rd_val = dir_q;
      ADDR_OUT:     rd_val = out_q;
      ADDR_IN:      rd_val = sync;
      ADDR_RISE_EN: rd_val = ren_q;
      ADDR_FALL_EN: rd_val = fen_q;
      ADDR_STAT:    rd_val = stat_q;
      default:      rd_val = '0;
    endcase
    rdata_d = bus.i_re ? DW'(rd_val) : rdata_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      dir_q    <= '0;
      out_q    <= '0;
      ren_q    <= '0;
      fen_q    <= '0;
      stat_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      dir_q    <= dir_d;
      out_q    <= out_d;
      ren_q    <= ren_d;
      fen_q    <= fen_d;
      stat_q   <= stat_d;
      rdata_q  <= rdata_d;
      rvalid_q <= bus.i_re;
      irq_q    <= |stat_q;
    end
  end

  assign bus.o_rdata  = rdata_q;
  assign bus.o_rvalid = rvalid_q;
  assign o_gpio_dir   = dir_q;
  assign o_gpio_out   = out_q;
  assign o_irq        = irq_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl: directed scenarios plus a
// randomized run checked against a cycle-level reference model.
module tb_gpio_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] gpio_in;
  logic [15:0] gpio_dir;
  logic [15:0] gpio_out;
  logic        irq;

  int tests_run    = 0;
  int tests_failed = 0;

  gpio_ctrl_if #(.DW(32)) bus ();

  gpio_ctrl #(.N(15), .DW(32)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .bus        (bus),
    .o_gpio_dir (gpio_dir),
    .o_gpio_out (gpio_out),
    .i_gpio_in  (gpio_in),
    .o_irq      (irq)
  );

  always #5 clk = ~clk;

  // reference model: register contents plus the pin value as seen
  // one and two clock edges ago
  logic [15:0] m_dir, m_out, m_ren, m_fen, m_stat;
  logic [15:0] m_last, m_prev;
  logic [31:0] m_rdata;
  logic        m_rvalid, m_irq;
  int          m_edges;

  task automatic model_reset();
    m_dir = 0; m_out = 0; m_ren = 0; m_fen = 0; m_stat = 0;
    m_last = 0; m_prev = 0; m_rdata = 0;
    m_rvalid = 0; m_irq = 0; m_edges = 0;
  endtask

  task automatic cyc();
    logic [15:0] rd, rs, fl, clr, wd;
    int a;
    a  = int'(bus.i_addr);
    wd = bus.i_wdata[15:0];
    @(posedge clk);
    case (a)
      0: rd = m_dir;
      1: rd = m_out;
      5: rd = m_last;
      6: rd = m_ren;
      7: rd = m_fen;
      8: rd = m_stat;
      default: rd = 0;
    endcase
    if (bus.i_re) m_rdata = {16'h0, rd};
    m_rvalid = bus.i_re;
    rs = 0; fl = 0;
    if (m_edges >= 2) begin
      rs = m_last & ~m_prev;
      fl = ~m_last & m_prev;
    end
    clr = (bus.i_we && a == 8) ? wd : 16'h0;
    m_irq  = (m_stat != 0);
    m_stat = (m_stat & ~clr) | (rs & m_ren) | (fl & m_fen);
    if (bus.i_we) begin
      case (a)
        0: m_dir = wd;
        1: m_out = wd;
        2: m_out = m_out | wd;
        3: m_out = m_out & ~wd;
        4: m_out = m_out ^ wd;
        6: m_ren = wd;
        7: m_fen = wd;
        default: ;
      endcase
    end
    m_prev = m_last;
    m_last = gpio_in;
    m_edges++;
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    bus.i_addr = 4'(a); bus.i_wdata = d; bus.i_we = 1'b1;
    cyc();
    bus.i_we = 1'b0;
  endtask

  task automatic rd(input int a);
    bus.i_addr = 4'(a); bus.i_re = 1'b1;
    cyc();
    bus.i_re = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    int addrs[4] = '{0, 1, 5, 8};
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({gpio_dir, gpio_out, irq, bus.o_rvalid} !== 34'h0 ||
        bus.o_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: dir=%h out=%h irq=%b rv=%b rd=%h want 0",
               gpio_dir, gpio_out, irq, bus.o_rvalid, bus.o_rdata);
    end
    rst = 1'b0;
    foreach (addrs[i]) begin
      rd(addrs[i]);
      tests_run++;
      if (bus.o_rvalid !== 1'b1 || bus.o_rdata !== 32'h0) begin
        tests_failed++;
        $display("FAIL reset_read a=%0d: rv=%b rd=%h want rv=1 rd=0",
                 addrs[i], bus.o_rvalid, bus.o_rdata);
      end
      cyc();
      tests_run++;
      if (bus.o_rvalid !== 1'b0) begin
        tests_failed++;
        $display("FAIL rvalid_pulse a=%0d: got %b want 0",
                 addrs[i], bus.o_rvalid);
      end
    end
    tests_run++;
    if (gpio_dir !== 16'h0 || irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle: dir=%h irq=%b want 0", gpio_dir, irq);
    end
  endtask

  task automatic test_out_ops();
    int          a[5] = '{0, 1, 2, 3, 4};
    logic [15:0] d[5] = '{16'h00FF, 16'h1234, 16'h0001, 16'h0200, 16'hF000};
    logic [15:0] e[5] = '{16'h0000, 16'h1234, 16'h1235, 16'h1035, 16'hE035};
    for (int i = 0; i < 5; i++) begin
      wr(a[i], {16'hDEAD, d[i]});
      tests_run++;
      if (gpio_out !== e[i]) begin
        tests_failed++;
        $display("FAIL out_op %0d: got %h want %h", i, gpio_out, e[i]);
      end
    end
    tests_run++;
    if (gpio_dir !== 16'h00FF) begin
      tests_failed++;
      $display("FAIL dir_write: got %h want 00ff", gpio_dir);
    end
    rd(1);
    tests_run++;
    if (bus.o_rdata !== 32'h0000E035) begin
      tests_failed++;
      $display("FAIL read_out: got %h want 0000e035", bus.o_rdata);
    end
    rd(2);
    tests_run++;
    if (bus.o_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL read_wo: got %h want 0", bus.o_rdata);
    end
  endtask

  task automatic test_in_hold();
    gpio_in = 16'hFFFF;
    do_reset();
    repeat (6) cyc();
    rd(8);
    tests_run++;
    if (bus.o_rdata !== 32'h0 || irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_stat: stat=%h irq=%b want 0", bus.o_rdata, irq);
    end
    rd(5);
    tests_run++;
    if (bus.o_rdata !== 32'h0000FFFF) begin
      tests_failed++;
      $display("FAIL hold_in: got %h want 0000ffff", bus.o_rdata);
    end
  endtask

  task automatic test_edges();
    logic [2:0] want_irq = 3'b100;
    gpio_in = 16'h8000;
    repeat (3) cyc();
    wr(6, 32'h0001);
    wr(7, 32'h8000);
    gpio_in = 16'h8001;
    for (int k = 0; k < 3; k++) begin
      cyc();
      tests_run++;
      if (irq !== want_irq[k]) begin
        tests_failed++;
        $display("FAIL irq_latency t+%0d: got %b want %b",
                 k + 1, irq, want_irq[k]);
      end
    end
    rd(8);
    tests_run++;
    if (bus.o_rdata !== 32'h0001) begin
      tests_failed++;
      $display("FAIL stat_rise: got %h want 0001", bus.o_rdata);
    end
    gpio_in = 16'h0001;
    repeat (3) cyc();
    rd(8);
    tests_run++;
    if (bus.o_rdata !== 32'h8001) begin
      tests_failed++;
      $display("FAIL stat_fall: got %h want 8001", bus.o_rdata);
    end
    wr(8, 32'h0001);
    rd(8);
    tests_run++;
    if (bus.o_rdata !== 32'h8000 || irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL stat_w1c: stat=%h irq=%b want 8000 irq=1",
               bus.o_rdata, irq);
    end
  endtask

  task automatic test_set_wins();
    gpio_in = 16'h0000;
    repeat (3) cyc();
    wr(8, 32'hFFFF);
    repeat (2) cyc();
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL irq_clear: got %b want 0", irq);
    end
    gpio_in = 16'h0001;
    cyc();
    wr(8, 32'h0001);
    rd(8);
    tests_run++;
    if (bus.o_rdata !== 32'h0001) begin
      tests_failed++;
      $display("FAIL set_wins: got %h want 0001", bus.o_rdata);
    end
  endtask

  task automatic test_rw_same();
    wr(6, 32'h0003);
    bus.i_addr = 4'd6; bus.i_wdata = 32'h00F0;
    bus.i_we = 1'b1; bus.i_re = 1'b1;
    cyc();
    bus.i_we = 1'b0; bus.i_re = 1'b0;
    tests_run++;
    if (bus.o_rdata !== 32'h0003) begin
      tests_failed++;
      $display("FAIL rw_same_old: got %h want 0003", bus.o_rdata);
    end
    rd(6);
    tests_run++;
    if (bus.o_rdata !== 32'h00F0) begin
      tests_failed++;
      $display("FAIL rw_same_new: got %h want 00f0", bus.o_rdata);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bus.i_addr  = 4'($urandom_range(0, 15));
      bus.i_we    = 1'($urandom_range(0, 1));
      bus.i_re    = 1'($urandom_range(0, 1));
      bus.i_wdata = $urandom;
      if ($urandom_range(0, 3) == 0) gpio_in = 16'($urandom);
      cyc();
      tests_run++;
      if (gpio_dir !== m_dir || gpio_out !== m_out || irq !== m_irq) begin
        tests_failed++;
        $display("FAIL rand_port %0d: dir=%h out=%h irq=%b want %h %h %b",
                 i, gpio_dir, gpio_out, irq, m_dir, m_out, m_irq);
      end
      tests_run++;
      if (bus.o_rvalid !== m_rvalid || bus.o_rdata !== m_rdata) begin
        tests_failed++;
        $display("FAIL rand_read %0d: rv=%b rd=%h want rv=%b rd=%h",
                 i, bus.o_rvalid, bus.o_rdata, m_rvalid, m_rdata);
      end
    end
    bus.i_we = 1'b0;
    bus.i_re = 1'b0;
  endtask

  task automatic test_reset_mid();
    wr(0, 32'h5A5A);
    wr(1, 32'hA5A5);
    bus.i_addr = 4'd1; bus.i_re = 1'b1;
    cyc();
    bus.i_re = 1'b0;
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (gpio_dir !== 16'h0 || gpio_out !== 16'h0 || irq !== 1'b0 ||
        bus.o_rvalid !== 1'b0 || bus.o_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_mid: dir=%h out=%h irq=%b rv=%b rd=%h want 0",
               gpio_dir, gpio_out, irq, bus.o_rvalid, bus.o_rdata);
    end
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    gpio_in      = 16'h0;
    bus.i_addr   = 4'h0;
    bus.i_we     = 1'b0;
    bus.i_re     = 1'b0;
    bus.i_wdata  = 32'h0;
    model_reset();
    test_reset();
    test_out_ops();
    test_in_hold();
    test_edges();
    test_set_wins();
    test_rw_same();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, want done");
    $fatal(1);
  end

endmodule

// File: doc/gpio_ctrl.md
Name: gpio_ctrl

Overview:
- Memory-mapped controller for the 16-bit GPIO port.
- Holds the direction and output registers that drive the port's direction and transmit inputs, and re-synchronises the port's received data.
- Detects rising and falling edges per pin and raises a level interrupt to the MIPS core.
- Sits between the core's data-memory bus (one word per register) and the GPIO port instance.

Parameters:
- N, 15, MSB index of the port (port width N+1), same convention as the GPIO port.
- DW, 32, bus data width; bits above N read as 0 and are ignored on write.

Ports:
- i_clk  input  1  system clock, all logic on posedge
- i_rst  input  1  asynchronous, active-high reset
- i_addr  input  4  register word index
- i_we  input  1  write strobe, one cycle per write
- i_re  input  1  read strobe, one cycle per read
- i_wdata  input  DW  write data
- o_rdata  output  DW  read data, registered
- o_rvalid  output  1  read data valid pulse
- o_gpio_dir  output  N+1  to port direction input (1 = drive pin)
- o_gpio_out  output  N+1  to port transmit data
- i_gpio_in  input  N+1  from port received data
- o_irq  output  1  level interrupt, registered

Behaviour:
- Reset (async, i_rst=1): all registers 0, so every pin is an input and outputs are low. o_rdata=0, o_rvalid=0, o_irq=0, edge-detect valid flag=0.
- Register map (i_addr):
  - 0 DIR: rw
  - 1 OUT: rw
  - 2 OUT_SET: wo, OUT |= wdata, reads 0
  - 3 OUT_CLR: wo, OUT &= ~wdata, reads 0
  - 4 OUT_TGL: wo, OUT ^= wdata, reads 0
  - 5 IN: ro, synchronised pin value
  - 6 RISE_EN: rw
  - 7 FALL_EN: rw
  - 8 STAT: rw1c, edge status
  - 9-15: unmapped; read 0, writes ignored
- Writes take effect at the posedge where i_we=1; o_gpio_dir and o_gpio_out update on that same edge.
- Reads: o_rdata and o_rvalid are registered, giving 1-cycle latency. o_rvalid=1 for exactly the cycle after the i_re cycle. o_rdata holds its value until the next read.
- i_we and i_re in the same cycle, same address: the read returns the pre-write value.
- Input path: i_gpio_in → sync flop s → previous flop p.
  - IN reads s.
  - rise = s & ~p, fall = ~s & p.
- Edge masking after reset: the valid flag sets on the 2nd posedge after reset deassertion. Until it is set, rise and fall are forced to 0, so no spurious edges are captured from reset values.
- STAT next value = (STAT & ~clr) | (rise & RISE_EN) | (fall & FALL_EN). clr = wdata when writing addr 8, else 0. Set wins over clear in the same cycle.
- Disabling an edge via RISE_EN/FALL_EN does not clear existing STAT bits.
- o_irq is registered: o_irq = |STAT, one cycle after STAT changes.
- Input edge to o_irq latency: an edge on i_gpio_in at cycle t sets STAT at t+2 and o_irq at t+3.
- A pin with DIR=1 still feeds the input path, so readback and edges reflect the driven value.
- Reset asserted mid-operation: everything returns to reset values immediately, including any pending read (o_rvalid drops).

Decomposition:
- Package gpio_ctrl_pkg: register index constants (ADDR_DIR … ADDR_STAT) and an address-decode enum shared with the bus decoder and firmware headers.
- One sub-module, gpio_edge_detect:
  - does sync, prev and valid-mask;
  - outputs rise/fall vectors;
  - is parameterised by N.
- Register file and read mux live in gpio_ctrl.

Test Plan:
- Reset then read addr 0, 1, 5, 8 → o_rdata=0 each, o_rvalid one cycle after each i_re, o_gpio_dir=0, o_irq=0.
- Write DIR=0x00FF and OUT=0x1234; OUT_SET 0x0001; OUT_CLR 0x0200; OUT_TGL 0xF000 → o_gpio_out sequence 0x1234, 0x1235, 0x1035, 0xE035; read OUT returns 0xE035; read addr 2 returns 0.
- Hold i_gpio_in=0xFFFF through reset release → STAT stays 0, o_irq stays 0, IN reads 0xFFFF.
- RISE_EN=0x0001, FALL_EN=0x8000; pulse pin0 0→1 at t → STAT=0x0001 at t+2, o_irq=1 at t+3. Drive pin15 1→0 → STAT=0x8001. Write STAT=0x0001 → STAT=0x8000, o_irq stays 1.
- Write STAT=0x0001 in the same cycle a new pin0 rising edge is captured → STAT bit0 remains 1.
- Same-cycle i_we and i_re to addr 6 with RISE_EN=0x0003, wdata 0x00F0 → o_rdata=0x0003; next read=0x00F0. Assert i_rst mid-sequence → all outputs 0 within the same cycle.
